// File: rtl/spi_audio_rx.sv
// SPI-style serial audio receiver: synchronises an external SCLK/MOSI/frame-select
// into clk_25mhz, assembles WORD_W-bit words and presents them with a ready/ack handshake.
module spi_audio_rx #(
    parameter int WORD_W      = 16,
    parameter int NUM_CH      = 2,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_25mhz,
    input  logic              reset,
    input  logic              sclk_in,
    input  logic              mosi_in,
    input  logic              active,
    input  logic              data_ack,
    output logic [WORD_W-1:0] audio_out,
    output logic [CH_W-1:0]   channel_out,
    output logic              data_ready,
    output logic              overrun,
    output logic              frame_error
);

    localparam int BC_W = $clog2(WORD_W);

    typedef enum logic {S_IDLE, S_RECV} state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_act_sync;
    logic                   r_sclk_prev;
    logic [BC_W-1:0]        r_bit_cnt;
    logic [CH_W-1:0]        r_ch_cnt;
    logic [WORD_W-1:0]      r_shift;
    logic [WORD_W-1:0]      r_audio;
    logic [CH_W-1:0]        r_channel;
    logic                   r_ready;
    logic                   r_overrun;
    logic                   r_frame_err;

    logic                   w_sclk;
    logic                   w_mosi;
    logic                   w_act;
    logic                   w_sclk_rise;
    logic                   w_start;
    logic                   w_shift;
    logic                   w_load;
    logic                   w_ferr;
    logic                   w_leave;
    logic [WORD_W-1:0]      w_sr_next;

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_act       = r_act_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_prev;

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_act_sync  <= '0;
            r_sclk_prev <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_in};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_in};
            r_act_sync  <= {r_act_sync[SYNC_STAGES-2:0], active};
            r_sclk_prev <= w_sclk;
        end
    end

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Frame end takes priority over a coincident SCLK rise: the bit is dropped.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_shift      = 1'b0;
        w_load       = 1'b0;
        w_ferr       = 1'b0;
        w_leave      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_act) begin
                    w_state_next = S_RECV;
                    w_start      = 1'b1;
                end
            end
            S_RECV: begin
                if (!w_act) begin
                    w_state_next = S_IDLE;
                    w_leave      = 1'b1;
                    w_ferr       = (r_bit_cnt != '0);
                end else if (w_sclk_rise) begin
                    w_shift = 1'b1;
                    w_load  = (r_bit_cnt == BC_W'(WORD_W - 1));
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        if (MSB_FIRST != 0) w_sr_next = {r_shift[WORD_W-2:0], w_mosi};
        else                w_sr_next = {w_mosi, r_shift[WORD_W-1:1]};
    end

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            r_bit_cnt   <= '0;
            r_ch_cnt    <= '0;
            r_shift     <= '0;
            r_audio     <= '0;
            r_channel   <= '0;
            r_ready     <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_start) begin
                r_bit_cnt <= '0;
                r_ch_cnt  <= '0;
            end else if (w_leave) begin
                r_bit_cnt <= '0;
            end else if (w_shift) begin
                r_shift <= w_sr_next;
                if (w_load) begin
                    r_bit_cnt <= '0;
                    r_audio   <= w_sr_next;
                    r_channel <= r_ch_cnt;
                    r_ch_cnt  <= (r_ch_cnt == CH_W'(NUM_CH - 1)) ? '0 : r_ch_cnt + 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end

            if (w_load)        r_ready <= 1'b1;
            else if (data_ack) r_ready <= 1'b0;

            r_overrun   <= w_load & r_ready & ~data_ack;
            r_frame_err <= w_ferr;
        end
    end

    assign audio_out   = r_audio;
    assign channel_out = r_channel;
    assign data_ready  = r_ready;
    assign overrun     = r_overrun;
    assign frame_error = r_frame_err;

endmodule

// File: tb/tb_spi_audio_rx.sv
// Directed bench for spi_audio_rx: MSB-first default instance plus an LSB-first instance
// sharing the same serial stimulus.
module tb_spi_audio_rx;

    localparam int SYNC = 2;

    logic        clk;
    logic        reset;
    logic        sclk;
    logic        mosi;
    logic        active;
    logic        ack;

    logic [15:0] a_audio;
    logic [0:0]  a_ch;
    logic        a_rdy;
    logic        a_ov;
    logic        a_fe;
    logic [15:0] b_audio;
    logic [0:0]  b_ch;
    logic        b_rdy;
    logic        b_ov;
    logic        b_fe;

    int n_vec = 0;
    int n_err = 0;
    int ov_cnt = 0;
    int fe_cnt = 0;

    spi_audio_rx #(.WORD_W(16), .NUM_CH(2), .MSB_FIRST(1), .SYNC_STAGES(SYNC)) u_dut_msb (
        .clk_25mhz   (clk),
        .reset       (reset),
        .sclk_in     (sclk),
        .mosi_in     (mosi),
        .active      (active),
        .data_ack    (ack),
        .audio_out   (a_audio),
        .channel_out (a_ch),
        .data_ready  (a_rdy),
        .overrun     (a_ov),
        .frame_error (a_fe)
    );

    spi_audio_rx #(.WORD_W(16), .NUM_CH(2), .MSB_FIRST(0), .SYNC_STAGES(SYNC)) u_dut_lsb (
        .clk_25mhz   (clk),
        .reset       (reset),
        .sclk_in     (sclk),
        .mosi_in     (mosi),
        .active      (active),
        .data_ack    (ack),
        .audio_out   (b_audio),
        .channel_out (b_ch),
        .data_ready  (b_rdy),
        .overrun     (b_ov),
        .frame_error (b_fe)
    );

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    always @(negedge clk) begin
        if (a_ov === 1'b1) ov_cnt++;
        if (a_fe === 1'b1) fe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // SCLK half period is 6 clk cycles; edges placed on clk negedges to avoid races.
    task automatic send_bits(input logic [15:0] w, input int unsigned n, input bit msbf,
                             input bit meas, input bit ack_load);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            mosi = msbf ? w[15-i] : w[i];
            repeat (6) @(negedge clk);
            sclk = 1'b1;
            if (i == n - 1 && meas) begin
                int cnt;
                cnt = 0;
                while (a_rdy !== 1'b1 && cnt < 10) begin
                    @(posedge clk);
                    #1;
                    cnt++;
                end
                check("latency", cnt, SYNC + 1);
            end
            if (i == n - 1 && ack_load) begin
                repeat (SYNC) @(posedge clk);
                @(negedge clk);
                ack = 1'b1;
                @(negedge clk);
                ack = 1'b0;
            end
            repeat (6) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic start_frame();
        @(negedge clk);
        active = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic end_frame();
        @(negedge clk);
        active = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int ov0;
        int fe0;
        reset  = 1'b1;
        sclk   = 1'b0;
        mosi   = 1'b0;
        active = 1'b0;
        ack    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_audio", a_audio, 16'h0000);
        check("rst_ch", a_ch, 0);
        check("rst_rdy", a_rdy, 0);
        check("rst_ov", a_ov, 0);
        check("rst_fe", a_fe, 0);
        @(negedge clk);
        reset = 1'b0;

        // Two words with ack and latency measurement
        start_frame();
        send_bits(16'hA5A5, 16, 1'b1, 1'b1, 1'b0);
        check("w1_audio", a_audio, 16'hA5A5);
        check("w1_ch", a_ch, 0);
        check("w1_rdy", a_rdy, 1);
        pulse_ack();
        check("w1_acked", a_rdy, 0);
        send_bits(16'hBEEF, 16, 1'b1, 1'b1, 1'b0);
        check("w2_audio", a_audio, 16'hBEEF);
        check("w2_ch", a_ch, 1);
        pulse_ack();
        check("w2_acked", a_rdy, 0);
        check("w12_no_ov", ov_cnt, 0);

        // Overrun without ack
        send_bits(16'h1234, 16, 1'b1, 1'b1, 1'b0);
        check("o1_ch", a_ch, 0);
        send_bits(16'h5678, 16, 1'b1, 1'b0, 1'b0);
        check("o2_audio", a_audio, 16'h5678);
        check("o2_ch", a_ch, 1);
        check("o2_rdy", a_rdy, 1);
        check("o2_ov_pulses", ov_cnt, 1);
        pulse_ack();
        check("o2_acked", a_rdy, 0);
        pulse_ack();
        check("idle_ack_rdy", a_rdy, 0);
        check("idle_ack_audio", a_audio, 16'h5678);

        // Partial word then frame end
        send_bits(16'hFFFF, 9, 1'b1, 1'b0, 1'b0);
        end_frame();
        check("fe_pulses", fe_cnt, 1);
        check("fe_rdy", a_rdy, 0);
        check("fe_audio", a_audio, 16'h5678);
        start_frame();
        send_bits(16'h0F0F, 16, 1'b1, 1'b1, 1'b0);
        check("f2_audio", a_audio, 16'h0F0F);
        check("f2_ch", a_ch, 0);
        pulse_ack();

        // Ack on the exact load edge of the next word
        send_bits(16'h1111, 16, 1'b1, 1'b1, 1'b0);
        ov0 = ov_cnt;
        send_bits(16'h2222, 16, 1'b1, 1'b0, 1'b1);
        check("al_audio", a_audio, 16'h2222);
        check("al_rdy", a_rdy, 1);
        check("al_ch", a_ch, 0);
        check("al_no_ov", ov_cnt, ov0);
        pulse_ack();

        // Frame end on a word boundary
        fe0 = fe_cnt;
        end_frame();
        check("clean_end_fe", fe_cnt, fe0);

        // Reset mid-word
        start_frame();
        send_bits(16'hC3C3, 8, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        reset  = 1'b1;
        active = 1'b0;
        #1;
        check("mr_audio", a_audio, 16'h0000);
        check("mr_ch", a_ch, 0);
        check("mr_rdy", a_rdy, 0);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("mr_no_fe", fe_cnt, fe0);
        start_frame();
        send_bits(16'hC3C3, 16, 1'b1, 1'b1, 1'b0);
        check("mr2_audio", a_audio, 16'hC3C3);
        check("mr2_ch", a_ch, 0);
        pulse_ack();

        // LSB-first word: the LSB-first instance sees 00F1, the MSB-first one its reversal
        send_bits(16'h00F1, 16, 1'b0, 1'b1, 1'b0);
        check("lsb_audio", b_audio, 16'h00F1);
        check("lsb_rdy", b_rdy, 1);
        check("lsb_rev_msb", a_audio, 16'h8F00);
        pulse_ack();
        end_frame();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
